// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multi-cycle RV32I-subset CPU (R-type, addi, lw,
//   sw, beq). Produces the ALUOp code for the ALU control decoder, the
//   datapath mux selects and write enables, and sequences the shared memory
//   port. Illegal opcodes and memory timeouts park the FSM in ERROR until
//   reset.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active high
//   start_i       leave IDLE and begin fetching
//   opcode_i[6:0] IR[6:0], valid from DECODE onward
//   zero_i        ALU zero flag (beq decision)
//   mem_ready_i   memory completes the current request this cycle
//   mem_req_o     memory request
//   mem_we_o      memory write (sw)
//   iord_o        memory address select: 0 = PC, 1 = ALUOut
//   ir_we_o       latch IR
//   pc_we_o       write PC
//   pc_src_o      PC source: 0 = ALU result, 1 = ALUOut
//   alu_src_a_o   ALU A select: 00 PC, 01 rs1, 10 oldPC
//   alu_src_b_o   ALU B select: 00 rs2, 01 const 4, 10 imm
//   ALUOp         00 add, 01 sub (beq), 10 funct-decoded
//   reg_we_o      register file write
//   mem_to_reg_o  writeback source: 0 = ALUOut, 1 = MDR
//   state_o       current state encoding
//   err_code_o    00 none, 01 illegal opcode, 10 memory timeout
//   instr_cnt_o   retired instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_src_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  ALUOp,
    output logic        reg_we_o,
    output logic        mem_to_reg_o,
    output logic [3:0]  state_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_next;
    logic [1:0]        err_code, err_next;
    logic [31:0]       instr_cnt, instr_next;
    logic              mem_state;

    // Memory handshake: mem_req_o is a valid that stays high for every cycle
    // the FSM sits in FETCH/MEM_RD/MEM_WR; the request completes in the cycle
    // mem_ready_i is sampled high together with mem_req_o, and the FSM moves
    // on at that clock edge. A ready without a request is ignored.

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            err_code  <= 2'b00;
            instr_cnt <= 32'd0;
        end else begin
            state     <= state_next;
            tmo_cnt   <= tmo_cnt_next;
            err_code  <= err_next;
            instr_cnt <= instr_next;
        end
    end

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    always_comb begin
        state_next   = state;
        err_next     = err_code;
        instr_next   = instr_cnt;
        tmo_cnt_next = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        ALUOp        = 2'b00;
        reg_we_o     = 1'b0;
        mem_to_reg_o = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) state_next = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 is computed by the ALU while the fetch is outstanding.
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_we_o    = 1'b1;
                    pc_we_o    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    OP_R:               state_next = S_EXEC_R;
                    OP_I:               state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_next = S_ADDR;
                    OP_BRANCH:          state_next = S_BRANCH;
                    default: begin
                        state_next = S_ERROR;
                        err_next   = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_o = 2'b01;
                ALUOp       = 2'b10;
                state_next  = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                state_next  = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                // opcode bit 5 separates store (0100011) from load (0000011).
                state_next  = opcode_i[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) begin
                    state_next = S_FETCH;
                    instr_next = instr_cnt + 32'd1;
                end
            end
            S_WB_ALU: begin
                reg_we_o   = 1'b1;
                state_next = S_FETCH;
                instr_next = instr_cnt + 32'd1;
            end
            S_WB_MEM: begin
                reg_we_o     = 1'b1;
                mem_to_reg_o = 1'b1;
                state_next   = S_FETCH;
                instr_next   = instr_cnt + 32'd1;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'b01;
                ALUOp       = 2'b01;
                pc_src_o    = 1'b1;
                pc_we_o     = zero_i;
                state_next  = S_FETCH;
                instr_next  = instr_cnt + 32'd1;
            end
            S_ERROR: begin
                // Sticky: only rst_i leaves this state.
                state_next = S_ERROR;
            end
            default: begin
                state_next = S_ERROR;
            end
        endcase

        // Stall accounting. The counter holds the number of not-ready cycles
        // already spent in this memory state, so the limit cycle is the one
        // where it reads TIMEOUT_CYCLES-1; a ready in that cycle still wins.
        if (mem_state && !mem_ready_i) begin
            if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                state_next = S_ERROR;
                err_next   = 2'b10;
            end else begin
                tmo_cnt_next = tmo_cnt + 1'b1;
            end
        end
    end

    assign state_o     = state;
    assign err_code_o  = err_code;
    assign instr_cnt_o = instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl, built with TIMEOUT_CYCLES = 4 so the
//   timeout limit and the ready-on-the-limit-cycle boundary are both reachable
//   with short stalls.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  aluop;
    logic        reg_we;
    logic        mem_to_reg;
    logic [3:0]  state;
    logic [1:0]  err_code;
    logic [31:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    multicycle_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W(5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .iord_o      (iord),
        .ir_we_o     (ir_we),
        .pc_we_o     (pc_we),
        .pc_src_o    (pc_src),
        .alu_src_a_o (alu_src_a),
        .alu_src_b_o (alu_src_b),
        .ALUOp       (aluop),
        .reg_we_o    (reg_we),
        .mem_to_reg_o(mem_to_reg),
        .state_o     (state),
        .err_code_o  (err_code),
        .instr_cnt_o (instr_cnt)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bound on total run time in case the sequence stalls.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] s;
        rst       = 1'b1;
        start     = 1'b0;
        opcode    = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        settle();

        // Reset state: every output 0.
        chk("rst_state", state, 0);
        chk("rst_err", err_code, 0);
        chk("rst_instr", instr_cnt, 0);
        chk("rst_outs", {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                         alu_src_b, aluop, reg_we, mem_to_reg}, 0);
        tick();
        rst = 1'b0;

        // 1: R-type, zero wait states.
        start     = 1'b1;
        opcode    = 7'b0110011;
        mem_ready = 1'b1;
        settle();
        chk("t1_idle", state, 0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd1);
        while (exp_q.size() > 0) begin
            tick();
            start = 1'b0;
            settle();
            s = exp_q.pop_front();
            chk("t1_state", state, s);
            chk("t1_aluop", aluop, (s == 4'd3) ? 2'b10 : 2'b00);
            chk("t1_reg_we", reg_we, (s == 4'd8) ? 1 : 0);
        end
        chk("t1_instr", instr_cnt, 1);

        // 2: lw with 3 stall cycles in MEM_RD; ready lands on the limit cycle.
        opcode = 7'b0000011;
        tick(); settle();
        chk("t2_decode", state, 2);
        chk("t2_dec_ab", {alu_src_a, alu_src_b}, 4'b1010);
        tick(); settle();
        chk("t2_addr", state, 5);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ready = 1'b1;
            settle();
            chk("t2_memrd_state", state, 6);
            chk("t2_memrd_req", {mem_req, iord, mem_we}, 3'b110);
        end
        tick(); settle();
        chk("t2_wbmem", state, 9);
        chk("t2_wbmem_en", {reg_we, mem_to_reg}, 2'b11);
        tick(); settle();
        chk("t2_fetch", state, 1);
        chk("t2_instr", instr_cnt, 2);
        chk("t2_err", err_code, 0);

        // 3: beq taken, then not taken.
        opcode = 7'b1100011;
        zero   = 1'b1;
        tick(); settle();
        chk("t3_dec_pcwe", pc_we, 0);
        tick(); settle();
        chk("t3_branch", state, 10);
        chk("t3_taken", {pc_we, pc_src, aluop, alu_src_a, alu_src_b}, 8'b11_01_01_00);
        tick(); settle();
        chk("t3_fetch", state, 1);
        chk("t3_instr", instr_cnt, 3);
        zero = 1'b0;
        tick(); tick(); settle();
        chk("t3_branch2", state, 10);
        chk("t3_not_taken", {pc_we, pc_src, aluop}, 4'b0_1_01);
        tick(); settle();
        chk("t3_instr2", instr_cnt, 4);

        // 4: illegal opcode, start_i ignored in ERROR, reset recovers.
        opcode = 7'b1111111;
        tick(); tick(); settle();
        chk("t4_error", state, 15);
        chk("t4_err", err_code, 1);
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            tick(); settle();
            chk("t4_hold_state", state, 15);
            chk("t4_hold_err", err_code, 1);
            chk("t4_hold_outs", {mem_req, pc_we, ir_we, reg_we, mem_we}, 0);
        end
        start = 1'b0;
        rst   = 1'b1;
        settle();
        chk("t4_rst_state", state, 0);
        chk("t4_rst_err", err_code, 0);
        chk("t4_rst_instr", instr_cnt, 0);
        tick();
        rst = 1'b0;

        // 5b: fetch stalls 3 cycles, ready on the 4th: no error. Runs addi.
        start     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'b0010011;
        tick();
        start = 1'b0;
        settle();
        chk("t5b_fetch1", state, 1);
        chk("t5b_irwe0", ir_we, 0);
        tick(); tick(); tick();
        mem_ready = 1'b1;
        settle();
        chk("t5b_fetch4", state, 1);
        chk("t5b_fetch4_we", {ir_we, pc_we, pc_src}, 3'b110);
        tick(); settle();
        chk("t5b_decode", state, 2);
        chk("t5b_noerr", err_code, 0);
        tick(); settle();
        chk("t5b_execi", state, 4);
        chk("t5b_execi_sel", {alu_src_a, alu_src_b, aluop}, 6'b01_10_00);
        tick(); tick(); settle();
        chk("t5b_instr", instr_cnt, 1);

        // sw completing after one wait cycle.
        opcode = 7'b0100011;
        tick(); tick(); settle();
        chk("sw_addr", state, 5);
        mem_ready = 1'b0;
        tick(); settle();
        chk("sw_memwr", state, 7);
        chk("sw_memwr_outs", {mem_req, mem_we, iord}, 3'b111);
        mem_ready = 1'b1;
        tick(); settle();
        chk("sw_fetch", state, 1);
        chk("sw_instr", instr_cnt, 2);

        // 6: reset asserted mid-cycle in MEM_WR.
        tick(); tick();
        mem_ready = 1'b0;
        tick(); settle();
        chk("t6_memwr", state, 7);
        chk("t6_req_before", {mem_req, mem_we}, 2'b11);
        #2;
        rst = 1'b1;
        settle();
        chk("t6_req_after", {mem_req, mem_we, iord}, 0);
        chk("t6_state", state, 0);
        chk("t6_instr", instr_cnt, 0);
        tick();
        rst = 1'b0;
        tick(); tick(); settle();
        chk("t6_no_restart", state, 0);

        // 5a: fetch never ready -> ERROR after exactly 4 FETCH cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        chk("t5a_fetch1", state, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("t5a_fetch_n", state, 1);
        end
        tick(); settle();
        chk("t5a_error", state, 15);
        chk("t5a_err", err_code, 2);
        chk("t5a_req", mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
